usb_fs_out_ep_buf: RTL and testbench

- Single-packet OUT/SETUP receive buffer for a full-speed USB endpoint.
- Sits between the USB protocol receive engine and the control/vendor endpoint logic. Upstream it captures data-packet bytes, checks data toggle and length, and decides the ACK/NAK/STALL handshake.
- Downstream it replays the held packet through the out_ep_* request/grant/get interface that the control endpoint consumes.

---
 rtl/usb_fs_out_ep_buf.sv | 225 ++++++++++++++++++++++
 tb/tb_usb_fs_out_ep_buf.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_fs_out_ep_buf.sv
// Single-packet OUT/SETUP receive buffer for a full-speed USB endpoint.
// Captures data-packet bytes from the receive engine, checks the data toggle
// and the length, and picks the ACK/NAK/STALL handshake. It then replays the
// held packet to the control endpoint through the out_ep_* interface.
// Ports:
//   clk, reset_n          : 48 MHz clock, async active-low reset
//   rx_xfr_start/setup    : OUT/SETUP token decoded for this endpoint
//   rx_pid_data1          : DATA1 (1) / DATA0 (0), valid at rx_pkt_end
//   rx_data_put, rx_data  : one payload byte per put
//   rx_pkt_end/valid      : end of the data packet, CRC and bit-stuffing good
//   tx_hs_ack/nak/stall   : one-cycle handshake requests
//   out_ep_req/grant      : consumer arbitration (grant is combinational)
//   out_ep_data_avail     : unread bytes remain in the held packet
//   out_ep_setup          : held packet came from a SETUP transaction
//   out_ep_data_get/data  : byte pop, data valid the cycle after the get
//   out_ep_stall          : endpoint halted by the consumer
//   out_ep_acked          : pulses with every ACK this block issues
module usb_fs_out_ep_buf #(
  parameter int unsigned MAX_PKT_SIZE = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_xfr_start,
  input  logic       rx_xfr_setup,
  input  logic       rx_pid_data1,
  input  logic       rx_data_put,
  input  logic [7:0] rx_data,
  input  logic       rx_pkt_end,
  input  logic       rx_pkt_valid,
  output logic       tx_hs_ack,
  output logic       tx_hs_nak,
  output logic       tx_hs_stall,
  input  logic       out_ep_req,
  output logic       out_ep_grant,
  output logic       out_ep_data_avail,
  output logic       out_ep_setup,
  input  logic       out_ep_data_get,
  output logic [7:0] out_ep_data,
  input  logic       out_ep_stall,
  output logic       out_ep_acked
);

  localparam int unsigned AW = $clog2(MAX_PKT_SIZE);
  localparam int unsigned PW = AW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RECV = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_DISC = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] len_q, len_d;
  logic          tog_q, tog_d;             // expected data toggle, 1 = DATA1
  logic          setup_flag_q, setup_flag_d;
  logic          ovf_q, ovf_d;
  logic          disc_stall_q, disc_stall_d; // pending DISCARD result: 1 = STALL
  logic          disc_held_q, disc_held_d;   // DISCARD returns to HOLD
  logic          ack_q, ack_d;
  logic          nak_q, nak_d;
  logic          stall_q, stall_d;
  logic          acked_q, acked_d;
  logic          setup_out_q, setup_out_d;
  logic [7:0]    data_q, data_d;
  logic          mem_we;
  logic          pop;
  logic          held_now;

  logic [7:0]    mem_q [MAX_PKT_SIZE];

  assign tx_hs_ack         = ack_q;
  assign tx_hs_nak         = nak_q;
  assign tx_hs_stall       = stall_q;
  assign out_ep_acked      = acked_q;
  assign out_ep_setup      = setup_out_q;
  assign out_ep_data       = data_q;
  assign out_ep_grant      = out_ep_req && (state_q == S_HOLD);
  assign out_ep_data_avail = (state_q == S_HOLD) && (rd_ptr_q < len_q);
  assign pop               = out_ep_data_get && out_ep_grant && out_ep_data_avail;

  // Next-state and datapath control.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    len_d        = len_q;
    tog_d        = tog_q;
    setup_flag_d = setup_flag_q;
    ovf_d        = ovf_q;
    disc_stall_d = disc_stall_q;
    disc_held_d  = disc_held_q;
    ack_d        = 1'b0;
    nak_d        = 1'b0;
    stall_d      = 1'b0;
    acked_d      = 1'b0;
    setup_out_d  = setup_out_q;
    data_d       = data_q;
    mem_we       = 1'b0;
    held_now     = (state_q == S_HOLD) || ((state_q == S_DISC) && disc_held_q);

    case (state_q)
      S_RECV: begin
        if (rx_data_put) begin
          if (wr_ptr_q < PW'(MAX_PKT_SIZE)) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
        if (rx_pkt_end) begin
          if (!rx_pkt_valid || ovf_q) begin
            // Corrupt or oversized: stay silent so the host retries.
            state_d  = S_IDLE;
            wr_ptr_d = '0;
            len_d    = '0;
          end else if (rx_pid_data1 != tog_q) begin
            // Retransmission of a packet already taken: re-ACK, drop data.
            ack_d    = 1'b1;
            acked_d  = 1'b1;
            state_d  = S_IDLE;
            wr_ptr_d = '0;
          end else begin
            ack_d       = 1'b1;
            acked_d     = 1'b1;
            tog_d       = ~tog_q;
            len_d       = wr_ptr_q;
            rd_ptr_d    = '0;
            setup_out_d = setup_flag_q && (wr_ptr_q != '0);
            state_d     = (wr_ptr_q != '0) ? S_HOLD : S_IDLE;
          end
        end
      end
      S_HOLD: begin
        if (pop) begin
          data_d   = mem_q[rd_ptr_q[AW-1:0]];
          rd_ptr_d = rd_ptr_q + PW'(1);
        end else if (rd_ptr_q >= len_q) begin
          // Leave one cycle after the last pop so the final byte stays valid.
          state_d     = S_IDLE;
          setup_out_d = 1'b0;
        end
      end
      S_DISC: begin
        if (rx_pkt_end) begin
          stall_d = disc_stall_q;
          nak_d   = ~disc_stall_q;
          state_d = disc_held_q ? S_HOLD : S_IDLE;
        end
      end
      default: ;
    endcase

    // Token decode overrides the per-state behaviour above.
    if (rx_xfr_start) begin
      if (rx_xfr_setup) begin
        state_d      = S_RECV;
        wr_ptr_d     = '0;
        rd_ptr_d     = '0;
        len_d        = '0;
        tog_d        = 1'b0;
        setup_flag_d = 1'b1;
        ovf_d        = 1'b0;
        setup_out_d  = 1'b0;
      end else if (out_ep_stall) begin
        state_d      = S_DISC;
        disc_stall_d = 1'b1;
        disc_held_d  = held_now;
      end else if (state_q == S_IDLE) begin
        state_d      = S_RECV;
        setup_flag_d = 1'b0;
        wr_ptr_d     = '0;
        ovf_d        = 1'b0;
      end else begin
        state_d      = S_DISC;
        disc_stall_d = 1'b0;
        disc_held_d  = held_now;
      end
    end
  end

  // State and control registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      len_q        <= '0;
      tog_q        <= 1'b0;
      setup_flag_q <= 1'b0;
      ovf_q        <= 1'b0;
      disc_stall_q <= 1'b0;
      disc_held_q  <= 1'b0;
      ack_q        <= 1'b0;
      nak_q        <= 1'b0;
      stall_q      <= 1'b0;
      acked_q      <= 1'b0;
      setup_out_q  <= 1'b0;
      data_q       <= 8'h00;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      len_q        <= len_d;
      tog_q        <= tog_d;
      setup_flag_q <= setup_flag_d;
      ovf_q        <= ovf_d;
      disc_stall_q <= disc_stall_d;
      disc_held_q  <= disc_held_d;
      ack_q        <= ack_d;
      nak_q        <= nak_d;
      stall_q      <= stall_d;
      acked_q      <= acked_d;
      setup_out_q  <= setup_out_d;
      data_q       <= data_d;
    end
  end

  // Packet storage; contents are only meaningful below len.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q[AW-1:0]] <= rx_data;
  end

endmodule

// File: tb/tb_usb_fs_out_ep_buf.sv
// Testbench for usb_fs_out_ep_buf: scenario tasks drive token/data/end
// sequences; bytes of packets that must be accepted are queued on exp_q and
// checked as the consumer pops them.
module tb_usb_fs_out_ep_buf;

  logic       clk;
  logic       reset_n;
  logic       rx_xfr_start, rx_xfr_setup, rx_pid_data1, rx_data_put;
  logic [7:0] rx_data;
  logic       rx_pkt_end, rx_pkt_valid;
  logic       tx_hs_ack, tx_hs_nak, tx_hs_stall;
  logic       out_ep_req, out_ep_grant, out_ep_data_avail, out_ep_setup;
  logic       out_ep_data_get;
  logic [7:0] out_ep_data;
  logic       out_ep_stall, out_ep_acked;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q [$];
  logic [7:0] setup_pkt [8] = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h12, 8'h00};

  usb_fs_out_ep_buf #(.MAX_PKT_SIZE(32)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .rx_xfr_start      (rx_xfr_start),
    .rx_xfr_setup      (rx_xfr_setup),
    .rx_pid_data1      (rx_pid_data1),
    .rx_data_put       (rx_data_put),
    .rx_data           (rx_data),
    .rx_pkt_end        (rx_pkt_end),
    .rx_pkt_valid      (rx_pkt_valid),
    .tx_hs_ack         (tx_hs_ack),
    .tx_hs_nak         (tx_hs_nak),
    .tx_hs_stall       (tx_hs_stall),
    .out_ep_req        (out_ep_req),
    .out_ep_grant      (out_ep_grant),
    .out_ep_data_avail (out_ep_data_avail),
    .out_ep_setup      (out_ep_setup),
    .out_ep_data_get   (out_ep_data_get),
    .out_ep_data       (out_ep_data),
    .out_ep_stall      (out_ep_stall),
    .out_ep_acked      (out_ep_acked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs rise on the falling edge and drop 1 time unit after the rising edge.
  task automatic token(input logic setup);
    @(negedge clk); rx_xfr_start = 1'b1; rx_xfr_setup = setup;
    @(posedge clk); #1; rx_xfr_start = 1'b0; rx_xfr_setup = 1'b0;
  endtask

  task automatic put_byte(input logic [7:0] d);
    @(negedge clk); rx_data_put = 1'b1; rx_data = d;
    @(posedge clk); #1; rx_data_put = 1'b0;
  endtask

  // hs1 is sampled the cycle after rx_pkt_end, hs2 one cycle later: {ack,nak,stall,acked}.
  task automatic end_pkt(input logic data1, input logic valid,
                         output logic [3:0] hs1, output logic [3:0] hs2);
    @(negedge clk); rx_pkt_end = 1'b1; rx_pid_data1 = data1; rx_pkt_valid = valid;
    @(posedge clk); #1; rx_pkt_end = 1'b0; rx_pid_data1 = 1'b0; rx_pkt_valid = 1'b0;
    hs1 = {tx_hs_ack, tx_hs_nak, tx_hs_stall, out_ep_acked};
    @(posedge clk); #1;
    hs2 = {tx_hs_ack, tx_hs_nak, tx_hs_stall, out_ep_acked};
  endtask

  // Full transaction; SETUP packets carry the standard descriptor request.
  task automatic xfer(input logic setup, input int n, input logic [7:0] base,
                      input logic data1, input logic valid, input logic push,
                      output logic [3:0] hs1, output logic [3:0] hs2);
    logic [7:0] b;
    token(setup);
    for (int i = 0; i < n; i++) begin
      b = (setup && i < 8) ? setup_pkt[i] : 8'(base + 8'(i));
      put_byte(b);
      if (push) exp_q.push_back(b);
    end
    end_pkt(data1, valid, hs1, hs2);
  endtask

  task automatic pop_byte(output logic [7:0] d, output logic av);
    @(negedge clk); out_ep_data_get = 1'b1;
    @(posedge clk); #1; out_ep_data_get = 1'b0;
    d  = out_ep_data;
    av = out_ep_data_avail;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; out_ep_req = 1'b1; out_ep_data_get = 1'b0; out_ep_stall = 1'b0;
    rx_xfr_start = 1'b0; rx_xfr_setup = 1'b0; rx_pid_data1 = 1'b0; rx_data_put = 1'b0;
    rx_data = 8'h00; rx_pkt_end = 1'b0; rx_pkt_valid = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({tx_hs_ack, tx_hs_nak, tx_hs_stall, out_ep_acked, out_ep_grant, out_ep_data_avail,
         out_ep_setup, out_ep_data} !== 15'h0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", {tx_hs_ack, tx_hs_nak, tx_hs_stall,
        out_ep_acked, out_ep_grant, out_ep_data_avail, out_ep_setup, out_ep_data});
    end
    reset_n = 1'b1;
  endtask

  task automatic test_setup();
    logic [3:0] hs1, hs2; logic [7:0] d, e; logic av;
    xfer(1'b1, 8, 8'h00, 1'b0, 1'b1, 1'b1, hs1, hs2);
    total++; if (hs1 !== 4'b1001) begin bad++; $display("FAIL setup_ack got=%b want=1001", hs1); end
    total++; if (hs2 !== 4'b0000) begin bad++; $display("FAIL setup_ack_pulse got=%b want=0000", hs2); end
    total++; if ({out_ep_setup, out_ep_data_avail, out_ep_grant} !== 3'b111) begin
      bad++; $display("FAIL setup_hold got=%b want=111", {out_ep_setup, out_ep_data_avail, out_ep_grant}); end
    for (int i = 0; i < 8; i++) begin
      pop_byte(d, av);
      e = exp_q.pop_front();
      total++; if (d !== e) begin bad++; $display("FAIL setup_byte%0d got=%h want=%h", i, d, e); end
      total++; if (av !== (i < 7)) begin bad++; $display("FAIL setup_avail%0d got=%b want=%b", i, av, (i < 7)); end
    end
    total++; if ({out_ep_grant, out_ep_setup} !== 2'b11) begin
      bad++; $display("FAIL setup_last_cycle got=%b want=11", {out_ep_grant, out_ep_setup}); end
    idle_cycle();
    total++; if ({out_ep_grant, out_ep_setup, out_ep_data_avail} !== 3'b000) begin
      bad++; $display("FAIL setup_idle got=%b want=000", {out_ep_grant, out_ep_setup, out_ep_data_avail}); end
  endtask

  task automatic test_nak_while_hold();
    logic [3:0] hs1, hs2; logic [7:0] d, e; logic av;
    xfer(1'b1, 8, 8'h00, 1'b0, 1'b1, 1'b1, hs1, hs2);
    total++; if (hs1 !== 4'b1001) begin bad++; $display("FAIL nak_setup_ack got=%b want=1001", hs1); end
    for (int i = 0; i < 5; i++) begin
      pop_byte(d, av); e = exp_q.pop_front();
      total++; if (d !== e) begin bad++; $display("FAIL nak_pre_byte%0d got=%h want=%h", i, d, e); end
    end
    xfer(1'b0, 4, 8'hAA, 1'b1, 1'b1, 1'b0, hs1, hs2);
    total++; if (hs1 !== 4'b0100) begin bad++; $display("FAIL nak_hs got=%b want=0100", hs1); end
    total++; if (hs2 !== 4'b0000) begin bad++; $display("FAIL nak_pulse got=%b want=0000", hs2); end
    total++; if ({out_ep_data_avail, out_ep_grant, out_ep_setup} !== 3'b111) begin
      bad++; $display("FAIL nak_still_held got=%b want=111", {out_ep_data_avail, out_ep_grant, out_ep_setup}); end
    for (int i = 5; i < 8; i++) begin
      pop_byte(d, av); e = exp_q.pop_front();
      total++; if (d !== e) begin bad++; $display("FAIL nak_held_byte%0d got=%h want=%h", i, d, e); end
    end
    idle_cycle();
    xfer(1'b0, 4, 8'hAA, 1'b1, 1'b1, 1'b1, hs1, hs2);
    total++; if (hs1 !== 4'b1001) begin bad++; $display("FAIL nak_retry_ack got=%b want=1001", hs1); end
    total++; if ({out_ep_setup, out_ep_data_avail} !== 2'b01) begin
      bad++; $display("FAIL nak_retry_flags got=%b want=01", {out_ep_setup, out_ep_data_avail}); end
    for (int i = 0; i < 4; i++) begin
      pop_byte(d, av); e = exp_q.pop_front();
      total++; if (d !== e) begin bad++; $display("FAIL nak_retry_byte%0d got=%h want=%h", i, d, e); end
    end
    idle_cycle();
  endtask

  task automatic test_repeat();
    logic [3:0] hs1, hs2; logic [7:0] d, e; logic av;
    xfer(1'b1, 8, 8'h00, 1'b0, 1'b1, 1'b1, hs1, hs2);
    for (int i = 0; i < 8; i++) begin pop_byte(d, av); e = exp_q.pop_front(); end
    idle_cycle();
    xfer(1'b0, 2, 8'h10, 1'b1, 1'b1, 1'b1, hs1, hs2);
    for (int i = 0; i < 2; i++) begin
      pop_byte(d, av); e = exp_q.pop_front();
      total++; if (d !== e) begin bad++; $display("FAIL rep_d1_byte%0d got=%h want=%h", i, d, e); end
    end
    idle_cycle();
    xfer(1'b0, 3, 8'h20, 1'b0, 1'b1, 1'b1, hs1, hs2);
    total++; if (hs1 !== 4'b1001) begin bad++; $display("FAIL rep_first_ack got=%b want=1001", hs1); end
    for (int i = 0; i < 3; i++) begin
      pop_byte(d, av); e = exp_q.pop_front();
      total++; if (d !== e) begin bad++; $display("FAIL rep_first_byte%0d got=%h want=%h", i, d, e); end
    end
    idle_cycle();
    xfer(1'b0, 3, 8'h30, 1'b0, 1'b1, 1'b0, hs1, hs2);
    total++; if (hs1 !== 4'b1001) begin bad++; $display("FAIL rep_dup_ack got=%b want=1001", hs1); end
    total++; if ({out_ep_data_avail, out_ep_grant} !== 2'b00) begin
      bad++; $display("FAIL rep_dup_nodata got=%b want=00", {out_ep_data_avail, out_ep_grant}); end
    xfer(1'b0, 1, 8'h40, 1'b1, 1'b1, 1'b1, hs1, hs2);
    total++; if ({hs1, out_ep_data_avail} !== 5'b10011) begin
      bad++; $display("FAIL rep_toggle_data1 got=%b want=10011", {hs1, out_ep_data_avail}); end
    pop_byte(d, av); e = exp_q.pop_front();
    total++; if (d !== e) begin bad++; $display("FAIL rep_toggle_byte got=%h want=%h", d, e); end
    idle_cycle();
  endtask

  task automatic test_zlp();
    logic [3:0] hs1, hs2; logic [7:0] d, e; logic av;
    xfer(1'b1, 8, 8'h00, 1'b0, 1'b1, 1'b1, hs1, hs2);
    for (int i = 0; i < 8; i++) begin pop_byte(d, av); e = exp_q.pop_front(); end
    idle_cycle();
    xfer(1'b0, 0, 8'h00, 1'b1, 1'b1, 1'b0, hs1, hs2);
    total++; if (hs1 !== 4'b1001) begin bad++; $display("FAIL zlp_ack got=%b want=1001", hs1); end
    total++; if (hs2 !== 4'b0000) begin bad++; $display("FAIL zlp_pulse got=%b want=0000", hs2); end
    total++; if ({out_ep_data_avail, out_ep_grant} !== 2'b00) begin
      bad++; $display("FAIL zlp_avail got=%b want=00", {out_ep_data_avail, out_ep_grant}); end
  endtask

  task automatic test_overflow_invalid();
    logic [3:0] hs1, hs2; logic [7:0] d, e; logic av;
    xfer(1'b0, 33, 8'h50, 1'b0, 1'b1, 1'b0, hs1, hs2);
    total++; if ({hs1, hs2} !== 8'h00) begin bad++; $display("FAIL ovf_silent got=%b want=00000000", {hs1, hs2}); end
    total++; if ({out_ep_data_avail, out_ep_grant} !== 2'b00) begin
      bad++; $display("FAIL ovf_empty got=%b want=00", {out_ep_data_avail, out_ep_grant}); end
    xfer(1'b0, 4, 8'h60, 1'b0, 1'b0, 1'b0, hs1, hs2);
    total++; if ({hs1, hs2} !== 8'h00) begin bad++; $display("FAIL crc_silent got=%b want=00000000", {hs1, hs2}); end
    total++; if (out_ep_data_avail !== 1'b0) begin bad++; $display("FAIL crc_empty got=%b want=0", out_ep_data_avail); end
    xfer(1'b0, 2, 8'h70, 1'b0, 1'b1, 1'b1, hs1, hs2);
    total++; if (hs1 !== 4'b1001) begin bad++; $display("FAIL ovf_after_ack got=%b want=1001", hs1); end
    for (int i = 0; i < 2; i++) begin
      pop_byte(d, av); e = exp_q.pop_front();
      total++; if (d !== e) begin bad++; $display("FAIL ovf_after_byte%0d got=%h want=%h", i, d, e); end
    end
    idle_cycle();
  endtask

  task automatic test_stall();
    logic [3:0] hs1, hs2; logic [7:0] d, e; logic av;
    out_ep_stall = 1'b1;
    xfer(1'b0, 2, 8'h90, 1'b1, 1'b1, 1'b0, hs1, hs2);
    total++; if (hs1 !== 4'b0010) begin bad++; $display("FAIL stall_out got=%b want=0010", hs1); end
    total++; if ({hs2, out_ep_data_avail} !== 5'b00000) begin
      bad++; $display("FAIL stall_out_after got=%b want=00000", {hs2, out_ep_data_avail}); end
    xfer(1'b1, 8, 8'h00, 1'b0, 1'b1, 1'b1, hs1, hs2);
    total++; if ({hs1, out_ep_setup} !== 5'b10011) begin
      bad++; $display("FAIL stall_setup_ack got=%b want=10011", {hs1, out_ep_setup}); end
    for (int i = 0; i < 8; i++) begin
      pop_byte(d, av); e = exp_q.pop_front();
      total++; if (d !== e) begin bad++; $display("FAIL stall_setup_byte%0d got=%h want=%h", i, d, e); end
    end
    idle_cycle();
    out_ep_stall = 1'b0;
  endtask

  task automatic test_reset_mid_recv();
    logic [3:0] hs1, hs2; logic [7:0] d, e; logic av;
    xfer(1'b1, 8, 8'h00, 1'b0, 1'b1, 1'b1, hs1, hs2);
    pop_byte(d, av); e = exp_q.pop_front();
    total++; if (d !== e) begin bad++; $display("FAIL rst_pre_byte got=%h want=%h", d, e); end
    exp_q.delete();
    token(1'b1);
    for (int i = 0; i < 5; i++) put_byte(8'(8'hE0 + 8'(i)));
    @(negedge clk); reset_n = 1'b0; #1;
    total++;
    if ({tx_hs_ack, tx_hs_nak, tx_hs_stall, out_ep_acked, out_ep_grant, out_ep_data_avail,
         out_ep_setup, out_ep_data} !== 15'h0) begin
      bad++; $display("FAIL rst_mid_outputs got=%h want=0", {tx_hs_ack, tx_hs_nak, tx_hs_stall,
        out_ep_acked, out_ep_grant, out_ep_data_avail, out_ep_setup, out_ep_data});
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    xfer(1'b1, 8, 8'h00, 1'b0, 1'b1, 1'b1, hs1, hs2);
    total++; if ({hs1, out_ep_setup, out_ep_data_avail} !== 6'b100111) begin
      bad++; $display("FAIL rst_after_setup got=%b want=100111", {hs1, out_ep_setup, out_ep_data_avail}); end
    for (int i = 0; i < 8; i++) begin
      pop_byte(d, av); e = exp_q.pop_front();
      total++; if (d !== e) begin bad++; $display("FAIL rst_after_byte%0d got=%h want=%h", i, d, e); end
    end
    idle_cycle();
  endtask

  initial begin
    test_reset();
    test_setup();
    test_nak_while_hold();
    test_repeat();
    test_zlp();
    test_overflow_invalid();
    test_stall();
    test_reset_mid_recv();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
